uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the team's fixed 8-bit UART receiver. Adds configurable data width, one or two stop bits, and 3-sample majority voting with start-bit glitch rejection. The received word is presented on a valid/ready handshake with a one-entry holding register and an overrun indication. Sits between the pad-side serial input and the byte consumer, such as a FIFO or register file.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 6, width of the prescale port; oversampling counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_in  in  1  asynchronous serial line; idles high
par_en  in  1  1 = parity bit present
par_typ  in  1  0 = even parity, 1 = odd parity
stop2  in  1  1 = two stop bits
prescale  in  PRESCALE_W  clocks per bit; legal values are >= 4
p_data  out  DATA_WIDTH  received word, LSB first on the line
par_err  out  1  parity mismatch for the word in p_data
stp_err  out  1  stop-bit error for the word in p_data
data_valid  out  1  p_data and the flags are valid
data_ready  in  1  consumer accepts when data_valid && data_ready
overrun  out  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset state: all outputs 0; p_data 0; FSM in IDLE; synchroniser flops set to 1; counters cleared.
- rx_in passes through a 2-flop synchroniser (rx_s). All timing below is relative to rx_s.
- Config latch: par_en, par_typ, stop2 and prescale are latched when a start edge is detected. Changes mid-frame have no effect until the next frame.
- Sample counter: scnt runs 0..P-1, where P is the latched prescale.
- Sample points: mid = P>>1. Samples are taken at scnt = mid-1, mid and mid+1. The bit value is the majority of the three samples.
- Bit counter: bcnt counts data bits 0..DATA_WIDTH-1.
- FSM transitions:
  - IDLE: rx_s = 0 -> START; scnt = 1.
  - START: majority = 1 at mid+1 -> IDLE (glitch; no output). Majority = 0 -> continue to end of bit (scnt = P-1) -> DATA.
  - DATA: shift the majority value in at bit position bcnt. After bit DATA_WIDTH-1 ends -> PARITY if par_en, else STOP.
  - PARITY: store the received parity bit; at end of bit -> STOP.
  - STOP: sample stop bit 1. If stop2, wait for end of bit -> STOP2. If not stop2, complete the frame at mid+1.
  - STOP2: sample stop bit 2; complete the frame at mid+1.
  - On completion -> IDLE immediately, so a back-to-back start bit half a bit later is caught.
- Parity check: computed = ^data for even parity, ~^data for odd parity. par_err = (received != computed) when par_en, else 0.
- Stop check: stp_err = 1 if any sampled stop bit is 0.
- Completion with the holding register empty:
  - p_data and the flags load on the next clock; data_valid rises on that same clock.
  - Latency: data_valid is high 1 clk after the last stop-bit sample (mid+1).
  - Frames with errors are still delivered, with the flags set.
- Completion with data_valid = 1 and no acceptance in the same cycle:
  - The new frame is discarded; overrun pulses for 1 clk.
  - The held p_data and flags are unchanged.
- Acceptance and completion in the same cycle: the new frame loads, data_valid stays 1, no overrun.
- While data_valid = 1 and data_ready = 0, p_data, par_err and stp_err are held stable.
- data_valid clears on the clock after acceptance.
- rst mid-frame: the frame is aborted, outputs clear, and the block returns to IDLE on the next clock edge.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined:
  - Adds output port break_det (1 bit).
  - A frame is a break when all data bits, the parity bit (if present) and the first stop bit are 0.
  - On a break: break_det pulses for 1 clk, no word is delivered, and no overrun is raised.
  - The FSM then waits in state BRK until rx_s = 1, then returns to IDLE.
- Undefined:
  - No break_det port and no BRK state.
  - The same frame is delivered as p_data = 0 with stp_err = 1.

Test Plan:
- Reset and basic frame:
  - Stimulus: rst high 2 clk; prescale 8, par_en 1, par_typ 1; send 0x09 with odd parity bit 1 and one stop bit; data_ready held 1.
  - Required: data_valid pulses once, p_data = 0x09, par_err = 0, stp_err = 0.
- Error flags:
  - Parity error: send 0x09 with even parity (par_typ 0) but a wrong parity bit of 1 -> p_data = 0x09, par_err = 1.
  - Stop error: separate frame with the stop bit forced to 0 -> stp_err = 1.
- Glitch rejection and majority voting:
  - Stimulus: a 2-clk low pulse on rx_in at prescale 16.
  - Required: no data_valid.
  - Stimulus: single-clk inverted spikes at each data bit's mid sample, sending 0xA5.
  - Required: p_data = 0xA5.
- Handshake and overrun:
  - Stimulus: data_ready = 0; send 0x11, then 0x22 back-to-back.
  - Required: p_data stays 0x11, overrun pulses 1 clk at the completion of 0x22.
  - Stimulus: raise data_ready.
  - Required: data_valid clears the next clk.
- Width and two stop bits:
  - Stimulus: DATA_WIDTH = 5, stop2 = 1, par_en = 0; send 0x15 with the second stop bit 0.
  - Required: p_data = 0x15, stp_err = 1.
  - Also: changing prescale from 8 to 16 mid-frame does not disturb that frame.
- Reset mid-frame and break:
  - Stimulus: assert rst during the data bits.
  - Required: no data_valid; the next clean frame 0x3C is received correctly.
  - Stimulus (UART_RX_BREAK_DET_EN defined): 12 bit-times low.
  - Required: break_det pulses once, no data_valid.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver
//
// Receives asynchronous serial frames (start, DATA_WIDTH data bits LSB first,
// optional parity, one or two stop bits) on rx_in. Each bit is resolved by a
// 3-sample majority vote around the bit centre. A start bit whose vote comes
// out high is treated as a glitch and ignored. Completed words go into a
// one-entry holding register and are offered on a valid/ready handshake.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   PRESCALE_W  width of the prescale port / oversampling counter
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx_in         serial line (asynchronous, idles high)
//   par_en        parity bit present
//   par_typ       0 = even, 1 = odd parity
//   stop2         two stop bits
//   prescale      clocks per bit (>= 4), latched at each start edge
//   p_data        received word
//   par_err       parity mismatch for the word in p_data
//   stp_err       a sampled stop bit was 0 for the word in p_data
//   data_valid    p_data and flags are valid
//   data_ready    consumer accepts when data_valid && data_ready
//   overrun       one-cycle pulse: a completed frame was dropped
//   break_det     (UART_RX_BREAK_DET_EN only) one-cycle pulse on a break frame
//
// Optional feature macro: UART_RX_BREAK_DET_EN

module uart_rx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                  break_det
`endif
);

  localparam int BCNT_W = $clog2(DATA_WIDTH);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
`ifdef UART_RX_BREAK_DET_EN
    ,
    BRK
`endif
  } state_t;

  // Synchroniser
  logic sync1_q;
  logic rx_s;

  // FSM
  state_t state_q;
  state_t state_d;

  // Frame configuration latched at the start edge
  logic [PRESCALE_W-1:0] p_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;

  // Counters and sample points
  logic [PRESCALE_W-1:0] scnt_q;
  logic [BCNT_W-1:0]     bcnt_q;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_m1;
  logic [PRESCALE_W-1:0] mid_p1;
  logic [PRESCALE_W-1:0] last;
  logic                  at_a;
  logic                  at_b;
  logic                  at_smp;
  logic                  at_end;

  // Samples and frame contents
  logic                  smp_a_q;
  logic                  smp_b_q;
  logic                  maj;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bit_q;
  logic                  stp_bad_q;

  // Completion strobes
  logic                  done;
  logic                  done_par_err;
  logic                  done_stp_err;
`ifdef UART_RX_BREAK_DET_EN
  logic                  brk;
`endif

  // ---------------------------------------------------------------------
  // Two-flop synchroniser, reset to the idle level
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s    <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Sample-point decode
  // ---------------------------------------------------------------------
  always_comb begin
    mid    = p_q >> 1;
    mid_m1 = mid - PRESCALE_W'(1);
    mid_p1 = mid + PRESCALE_W'(1);
    last   = p_q - PRESCALE_W'(1);
    at_a   = (scnt_q == mid_m1);
    at_b   = (scnt_q == mid);
    at_smp = (scnt_q == mid_p1);
    at_end = (scnt_q == last);
    // Third sample is the live rx_s at mid+1
    maj    = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);
  end

  // Received parity against the parity computed over the data bits;
  // odd parity is the inverted XOR reduction.
  assign done_par_err = par_en_q & (par_bit_q != (par_typ_q ^ (^data_q)));

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and completion strobes
  // With prescale = 4, mid+1 coincides with the end of the bit, so the
  // sample decision is always evaluated before the end-of-bit transition.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    done_stp_err = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk          = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (at_smp && maj) state_d = IDLE;
        else if (at_end)   state_d = DATA;
      end
      DATA: begin
        if (at_end && (bcnt_q == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end) state_d = STOP;
      end
      STOP: begin
`ifdef UART_RX_BREAK_DET_EN
        if (at_smp && !maj && (data_q == '0) && !(par_en_q && par_bit_q)) begin
          brk     = 1'b1;
          state_d = BRK;
        end else
`endif
        if (at_smp && !stop2_q) begin
          done         = 1'b1;
          done_stp_err = ~maj;
          state_d      = IDLE;
        end else if (at_end && stop2_q) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (at_smp) begin
          done         = 1'b1;
          done_stp_err = stp_bad_q | ~maj;
          state_d      = IDLE;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame datapath: config latch, counters, samples, shift register.
  // scnt is preloaded to 1 in IDLE so the detection cycle counts as 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      smp_a_q   <= 1'b1;
      smp_b_q   <= 1'b1;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      stp_bad_q <= 1'b0;
    end else if (state_q == IDLE) begin
      scnt_q <= PRESCALE_W'(1);
      bcnt_q <= '0;
      if (!rx_s) begin
        p_q       <= prescale;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        stop2_q   <= stop2;
        data_q    <= '0;
        par_bit_q <= 1'b0;
        stp_bad_q <= 1'b0;
      end
    end else begin
      scnt_q <= at_end ? '0 : scnt_q + PRESCALE_W'(1);
      if (at_a) smp_a_q <= rx_s;
      if (at_b) smp_b_q <= rx_s;
      if (state_q == DATA) begin
        if (at_smp) data_q[bcnt_q] <= maj;
        if (at_end) bcnt_q <= bcnt_q + BCNT_W'(1);
      end
      if ((state_q == PARITY) && at_smp) par_bit_q <= maj;
      if ((state_q == STOP) && at_smp)   stp_bad_q <= ~maj;
    end
  end

  // ---------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data     <= '0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!data_valid || data_ready) begin
          p_data     <= data_q;
          par_err    <= done_par_err;
          stp_err    <= done_stp_err;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      break_det <= 1'b0;
    end else begin
      break_det <= brk;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed, table-driven bench for uart_rx_param.
// Two instances: an 8-bit receiver for most frames and a 5-bit one for
// the width / two-stop-bit / mid-frame prescale cases.

module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 8-bit instance
  logic       rx8 = 1'b1;
  logic       pe8 = 1'b0;
  logic       pt8 = 1'b0;
  logic       s2_8 = 1'b0;
  logic [5:0] ps8 = 6'd8;
  logic [7:0] pd8;
  logic       per8, ser8, dv8, ov8;
  logic       rdy8 = 1'b1;

  // 5-bit instance
  logic       rx5 = 1'b1;
  logic       pe5 = 1'b0;
  logic       pt5 = 1'b0;
  logic       s2_5 = 1'b1;
  logic [5:0] ps5 = 6'd8;
  logic [4:0] pd5;
  logic       per5, ser5, dv5, ov5;
  logic       rdy5 = 1'b1;

`ifdef UART_RX_BREAK_DET_EN
  logic bd8, bd5;
`endif

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .par_en(pe8), .par_typ(pt8),
    .stop2(s2_8), .prescale(ps8), .p_data(pd8), .par_err(per8),
    .stp_err(ser8), .data_valid(dv8), .data_ready(rdy8), .overrun(ov8)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(bd8)
`endif
  );

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_W(6)) dut5 (
    .clk(clk), .rst(rst), .rx_in(rx5), .par_en(pe5), .par_typ(pt5),
    .stop2(s2_5), .prescale(ps5), .p_data(pd5), .par_err(per5),
    .stp_err(ser5), .data_valid(dv5), .data_ready(rdy5), .overrun(ov5)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(bd5)
`endif
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       se;
  } cap_t;

  cap_t q8[$];
  cap_t q5[$];
  int   ovr_cnt = 0;
  int   ovr5_cnt = 0;
  int   brk_cnt = 0;

  int checks = 0;
  int errors = 0;

  // Accepted words and pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (dv8 && rdy8) q8.push_back('{d: {1'b0, pd8}, pe: per8, se: ser8});
    if (dv5 && rdy5) q5.push_back('{d: {4'b0, pd5}, pe: per5, se: ser5});
    if (ov8) ovr_cnt++;
    if (ov5) ovr5_cnt++;
`ifdef UART_RX_BREAK_DET_EN
    if (bd8) brk_cnt++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic v, input int p, input bit spike);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (sel == 0) rx8 = (spike && i == p / 2) ? ~v : v;
      else          rx5 = (spike && i == p / 2) ? ~v : v;
    end
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input bit pen, input bit pbit, input bit two,
                            input bit s1, input bit s2, input int p, input bit spike);
    drive_bit(sel, 1'b0, p, 1'b0);
    for (int b = 0; b < nbits; b++) drive_bit(sel, d[b], p, spike);
    if (pen) drive_bit(sel, pbit, p, 1'b0);
    drive_bit(sel, s1, p, 1'b0);
    if (two) drive_bit(sel, s2, p, 1'b0);
  endtask

  task automatic check_word(input string name, input int sel, input logic [8:0] ed,
                            input logic epe, input logic ese);
    cap_t c;
    c = '{d: '0, pe: 1'b0, se: 1'b0};
    if (sel == 0) begin
      check({name, ".count"}, q8.size(), 1);
      if (q8.size() > 0) c = q8.pop_front();
      q8.delete();
    end else begin
      check({name, ".count"}, q5.size(), 1);
      if (q5.size() > 0) c = q5.pop_front();
      q5.delete();
    end
    check({name, ".p_data"}, c.d, ed);
    check({name, ".par_err"}, c.pe, epe);
    check({name, ".stp_err"}, c.se, ese);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_se;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          data   pen ptyp pbit stop  exp_d  pe se
    vecs[0] = '{8'h09, 1, 1, 1, 1, 8'h09, 0, 0};  // odd parity, correct
    vecs[1] = '{8'h09, 1, 0, 1, 1, 8'h09, 1, 0};  // even parity, wrong bit
    vecs[2] = '{8'h5A, 0, 0, 0, 0, 8'h5A, 0, 1};  // stop bit 0
    vecs[3] = '{8'hFF, 1, 0, 0, 1, 8'hFF, 0, 0};  // even, eight ones
    vecs[4] = '{8'h80, 1, 1, 0, 1, 8'h80, 0, 0};  // odd, one one
    vecs[5] = '{8'h00, 0, 0, 0, 1, 8'h00, 0, 0};  // zero data, good stop
    vecs[6] = '{8'h3C, 1, 0, 1, 1, 8'h3C, 1, 0};  // even, wrong bit

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.data_valid", dv8, 0);
    check("reset.p_data", pd8, 0);
    check("reset.par_err", per8, 0);
    check("reset.stp_err", ser8, 0);
    check("reset.overrun", ov8, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven frames at prescale 8
    for (int v = 0; v < 7; v++) begin
      pe8 = vecs[v].pen;
      pt8 = vecs[v].ptyp;
      send_frame(0, {1'b0, vecs[v].data}, 8, vecs[v].pen, vecs[v].pbit, 1'b0,
                 vecs[v].stop, 1'b1, 8, 1'b0);
      drive_bit(0, 1'b1, 8, 1'b0);
      repeat (2) @(negedge clk);
      check_word($sformatf("vec%0d", v), 0, {1'b0, vecs[v].exp_d},
                 vecs[v].exp_pe, vecs[v].exp_se);
    end

    // Glitch rejection: 2-clk low pulse at prescale 16
    pe8 = 1'b0;
    ps8 = 6'd16;
    repeat (4) @(negedge clk);
    @(negedge clk) rx8 = 1'b0;
    @(negedge clk) rx8 = 1'b0;
    @(negedge clk) rx8 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch.count", q8.size(), 0);
    check("glitch.data_valid", dv8, 0);
    q8.delete();

    // Single-clock inverted spikes at each data bit's centre
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b1);
    drive_bit(0, 1'b1, 16, 1'b0);
    check_word("spike", 0, 9'h0A5, 0, 0);

    // Handshake and overrun
    ps8 = 6'd8;
    rdy8 = 1'b0;
    repeat (4) @(negedge clk);
    begin
      int ovr0;
      ovr0 = ovr_cnt;
      send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
      drive_bit(0, 1'b1, 8, 1'b0);
      check("ovr.pulses", ovr_cnt - ovr0, 1);
      check("ovr.data_valid", dv8, 1);
      check("ovr.p_data_held", pd8, 8'h11);
      check("ovr.stp_err_held", ser8, 0);
      check("ovr.overrun_low", ov8, 0);
    end
    #1 rdy8 = 1'b1;
    @(negedge clk);
    check("ovr.dv_cleared", dv8, 0);
    q8.delete();

    // Width 5, two stop bits, second stop bit 0, prescale change mid-frame
    repeat (4) @(negedge clk);
    fork
      send_frame(1, 9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1'b0);
      begin
        repeat (12) @(negedge clk);
        ps5 = 6'd16;
      end
    join
    drive_bit(1, 1'b1, 8, 1'b0);
    repeat (2) @(negedge clk);
    check_word("w5.stop2err", 1, 9'h015, 0, 1);

    // Width 5 at the new prescale, both stop bits good
    send_frame(1, 9'h00A, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    drive_bit(1, 1'b1, 16, 1'b0);
    check_word("w5.clean", 1, 9'h00A, 0, 0);
    check("w5.overrun", ovr5_cnt, 0);

    // Reset during data bits
    drive_bit(0, 1'b0, 8, 1'b0);
    drive_bit(0, 1'b0, 8, 1'b0);
    drive_bit(0, 1'b0, 8, 1'b0);
    drive_bit(0, 1'b1, 8, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) begin
      rst = 1'b0;
      rx8 = 1'b1;
    end
    repeat (100) @(negedge clk);
    check("rstmid.count", q8.size(), 0);
    check("rstmid.data_valid", dv8, 0);
    q8.delete();
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
    drive_bit(0, 1'b1, 8, 1'b0);
    check_word("rstmid.next", 0, 9'h03C, 0, 0);

    // Break: 12 bit-times low
    begin
      int ovr0;
      ovr0 = ovr_cnt;
      for (int b = 0; b < 12; b++) drive_bit(0, 1'b0, 8, 1'b0);
      for (int b = 0; b < 30; b++) drive_bit(0, 1'b1, 8, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
      check("brk.pulses", brk_cnt, 1);
      check("brk.no_word", q8.size(), 0);
      check("brk.no_overrun", ovr_cnt - ovr0, 0);
`else
      begin
        cap_t c;
        c = '{d: 9'h1FF, pe: 1'b1, se: 1'b0};
        check("brk.delivered", q8.size() >= 1, 1);
        if (q8.size() > 0) c = q8[0];
        check("brk.p_data", c.d, 0);
        check("brk.stp_err", c.se, 1);
        check("brk.no_overrun", ovr_cnt - ovr0, 0);
      end
`endif
      q8.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
